// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Groups every handshake and bus signal around the shared ALU sequencer:
//   req0_* / req1_*  : operation requests (valid/ready, operands a/b, opcode)
//   rsp0_* / rsp1_*  : response handshake (valid/ready) per requester
//   rsp_out / rsp_z  : captured result and zero flag, shared by both responses
//   alu_a/alu_b/alu_op : registered operands/opcode driven toward the ALU
//   alu_out / alu_z  : combinational result and zero flag coming back from the ALU
//   busy             : sequencer is not idle
// Modport 'slave' is the arbiter's view; 'master' is the view of the
// surroundings (requesters plus the ALU instance).
interface alu_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_op;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_out;
    logic             rsp_z;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_z;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_out, rsp_z,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out, alu_z,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_out, rsp_z,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out, alu_z,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter and sequencer for a single shared ALU. Two requesters
// offer operations; the winner's operands are registered toward the ALU, the
// ALU result is captured after one execute cycle and handed back over the
// winner's response handshake. Only one operation is ever in flight.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_arbiter_if.slave carrying request, response and ALU signals
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             owner;
    logic             prio;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] out_reg;
    logic             z_reg;

    logic             in_idle;
    logic             grant1;
    logic             accept;
    logic             rsp_done;

    // Grant decision and handshake qualifiers. Requester 1 wins when it is
    // the only one asking, or when both ask and it holds priority. Readies
    // are also gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        in_idle  = rst_n && (state == IDLE);
        grant1   = bus.req1_valid && (!bus.req0_valid || prio);
        accept   = in_idle && (bus.req0_valid || bus.req1_valid);
        rsp_done = owner ? bus.rsp1_ready : bus.rsp0_ready;
    end

    assign bus.req0_ready = in_idle && bus.req0_valid && !grant1;
    assign bus.req1_ready = in_idle && grant1;

    assign bus.rsp0_valid = (state == RESP) && !owner;
    assign bus.rsp1_valid = (state == RESP) && owner;
    assign bus.rsp_out    = out_reg;
    assign bus.rsp_z      = z_reg;

    assign bus.alu_a      = a_reg;
    assign bus.alu_b      = b_reg;
    assign bus.alu_op     = op_reg;

    assign bus.busy       = (state != IDLE);

    // Sequencer: IDLE accepts the granted request and latches its operands,
    // EXEC lets the ALU settle for one cycle and captures its result, RESP
    // holds the result until the owner consumes it. The owner then drops to
    // lowest priority so contending requesters alternate. A reset mid-flight
    // simply discards the transaction and restores req0 as favoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            prio    <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= 2'b00;
            out_reg <= '0;
            z_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= grant1;
                        a_reg  <= grant1 ? bus.req1_a  : bus.req0_a;
                        b_reg  <= grant1 ? bus.req1_b  : bus.req0_b;
                        op_reg <= grant1 ? bus.req1_op : bus.req0_op;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    out_reg <= bus.alu_out;
                    z_reg   <= bus.alu_z;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        prio  <= ~owner;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
